// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq: valid/ready in, registered valid/ready out.
interface alu_seq_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       opcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_hi;
  logic [4:0]       flags;

  modport master (output in_valid, a, b, opcode, out_ready,
                  input  in_ready, out_valid, res, res_hi, flags);
  modport slave  (input  in_valid, a, b, opcode, out_ready,
                  output in_ready, out_valid, res, res_hi, flags);
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith ops plus a WIDTH-cycle unsigned shift-add multiply,
// with a registered, backpressure-tolerant result port.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_seq_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_e;
  typedef struct packed {
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic [4:0]       flags;   // {err, v, c, n, z}
  } rsp_t;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
                         OP_XOR = 4'd4, OP_NOT = 4'd5, OP_BIC = 4'd6, OP_ASR = 4'd7,
                         OP_LSR = 4'd8, OP_LSL = 4'd9, OP_MUL = 4'd10;
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] ma_q, ma_d, acc_q, acc_d;
  logic [WIDTH-1:0]   mb_q, mb_d;
  logic               out_valid_q, out_valid_d;
  rsp_t               rsp_q, rsp_d;

  logic               out_free, in_ready, accept, load;
  rsp_t               alu_rsp, load_rsp;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [WIDTH:0]     sum, diff;
  logic [WIDTH-1:0]   r;
  logic               c, v, err;

  function automatic rsp_t mul_rsp(input logic [2*WIDTH-1:0] p);
    rsp_t o;
    o.lo    = p[WIDTH-1:0];
    o.hi    = p[2*WIDTH-1:WIDTH];
    o.flags = {1'b0, 1'b0, (o.hi != '0), o.lo[WIDTH-1], (p == '0)};
    return o;
  endfunction

  always_comb begin
    sum  = {1'b0, bus.a} + {1'b0, bus.b};
    diff = {1'b0, bus.a} - {1'b0, bus.b};
    r    = '0;
    c    = 1'b0;
    v    = 1'b0;
    err  = 1'b0;
    unique case (bus.opcode)
      OP_ADD: begin
        r = sum[WIDTH-1:0];
        c = sum[WIDTH];
        v = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (r[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        r = diff[WIDTH-1:0];
        c = diff[WIDTH];    // borrow out == unsigned a < b
        v = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (r[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND: r = bus.a & bus.b;
      OP_OR:  r = bus.a | bus.b;
      OP_XOR: r = bus.a ^ bus.b;
      OP_NOT: r = ~bus.b;
      OP_BIC: r = bus.a & ~bus.b;
      OP_ASR: begin r = {bus.a[WIDTH-1], bus.a[WIDTH-1:1]}; c = bus.a[0]; end
      OP_LSR: begin r = {1'b0, bus.a[WIDTH-1:1]};           c = bus.a[0]; end
      OP_LSL: begin r = {bus.a[WIDTH-2:0], 1'b0};           c = bus.a[WIDTH-1]; end
      default: begin r = '1; err = 1'b1; end
    endcase
    alu_rsp = '{lo: r, hi: '0, flags: {err, v, c, r[WIDTH-1], (r == '0)}};
  end

  assign prod_nxt = acc_q + (mb_q[0] ? ma_q : '0);
  assign out_free = !out_valid_q || bus.out_ready;
  assign in_ready = (state_q == IDLE) && out_free;
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    acc_d    = acc_q;
    load     = 1'b0;
    load_rsp = alu_rsp;
    unique case (state_q)
      IDLE: if (accept) begin
        if (bus.opcode == OP_MUL) begin
          ma_d    = {{WIDTH{1'b0}}, bus.a};
          mb_d    = bus.b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end else begin
          load = 1'b1;
        end
      end
      BUSY: begin
        acc_d = prod_nxt;
        ma_d  = ma_q << 1;
        mb_d  = mb_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IT) begin
          cnt_d = '0;
          if (out_free) begin
            load     = 1'b1;
            load_rsp = mul_rsp(prod_nxt);
            state_d  = IDLE;
          end else begin
            state_d  = HOLD;
          end
        end
      end
      HOLD: if (out_free) begin
        load     = 1'b1;
        load_rsp = mul_rsp(acc_q);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A load wins over a drain, so drain+load in one cycle keeps out_valid high.
  always_comb begin
    out_valid_d = out_valid_q;
    rsp_d       = rsp_q;
    if (load) begin
      out_valid_d = 1'b1;
      rsp_d       = load_rsp;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ma_q        <= '0;
      mb_q        <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ma_q        <= ma_d;
      mb_q        <= mb_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      rsp_q       <= rsp_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.res       = rsp_q.lo;
  assign bus.res_hi    = rsp_q.hi;
  assign bus.flags     = rsp_q.flags;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: driver pushes reference results on accept, monitor pops on delivery.
module tb_alu_seq;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [4:0]   flags;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   rdy_mode = 0;   // 0 always ready, 1 random, 2 pattern 1,0,0,1, 3 low 15 cycles then high
  int   rdy_idx = 0;
  exp_t exp_q[$];

  alu_seq_if #(.WIDTH(W)) bus ();
  alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: straight arithmetic on integers.
  function automatic exp_t model(input logic [3:0] op, input int unsigned ia, input int unsigned ib);
    int unsigned r, hi, p;
    int sa, sb, sr;
    bit c, v, err;
    exp_t e;
    r = 0; hi = 0; c = 0; v = 0; err = 0;
    sa = (ia >= 128) ? int'(ia) - 256 : int'(ia);
    sb = (ib >= 128) ? int'(ib) - 256 : int'(ib);
    case (op)
      4'd0: begin r = (ia + ib) % 256; c = (ia + ib) > 255; sr = sa + sb; v = (sr > 127) || (sr < -128); end
      4'd1: begin r = (ia + 256 - ib) % 256; c = ia < ib; sr = sa - sb; v = (sr > 127) || (sr < -128); end
      4'd2: r = ia & ib;
      4'd3: r = ia | ib;
      4'd4: r = ia ^ ib;
      4'd5: r = 255 - ib;
      4'd6: r = ia & (255 - ib);
      4'd7: begin r = ia / 2 + ((ia >= 128) ? 128 : 0); c = ia % 2; end
      4'd8: begin r = ia / 2; c = ia % 2; end
      4'd9: begin r = (ia * 2) % 256; c = ia >= 128; end
      4'd10: begin p = ia * ib; r = p % 256; hi = p / 256; c = hi != 0; end
      default: begin r = 255; err = 1; end
    endcase
    e.res   = r[W-1:0];
    e.hi    = hi[W-1:0];
    e.flags = {err, v, c, (r >= 128), (r == 0 && hi == 0)};
    return e;
  endfunction

  always @(posedge clk) begin
    #1;
    rdy_idx++;
    case (rdy_mode)
      0: bus.out_ready = 1'b1;
      1: bus.out_ready = 1'($urandom_range(0, 1));
      2: bus.out_ready = (rdy_idx % 4 == 0) || (rdy_idx % 4 == 3);
      default: bus.out_ready = (rdy_idx > 15);
    endcase
  end

  // Monitor: checks every delivery against the scoreboard, output stability and in_ready gating.
  logic  stall = 1'b0;
  exp_t  held, cur, e_pop;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall = 1'b0;
    end else begin
      cur = {bus.res, bus.res_hi, bus.flags};
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL sb_unexpected: got res=%h with nothing pending, expected no result", bus.res);
        end else begin
          e_pop = exp_q.pop_front();
          chk("sb_result", 32'(cur), 32'(e_pop));
        end
      end
      if (stall && bus.out_valid) chk("stall_frozen", 32'(cur), 32'(held));
      if (bus.out_valid && !bus.out_ready) chk("in_ready_blocked", 32'(bus.in_ready), 32'd0);
      stall = bus.out_valid && !bus.out_ready;
      held  = cur;
    end
  end

  task automatic issue(input logic [3:0] op, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       output int acc_cyc);
    bit ok = 0;
    bus.in_valid = 1'b1; bus.opcode = op; bus.a = ia; bus.b = ib;
    for (int w = 0; w < 100; w++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: got in_ready=0 for 100 cycles, expected 1");
      acc_cyc = -1;
    end else begin
      exp_q.push_back(model(op, ia, ib));
      acc_cyc = cyc;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Issue with out_ready high and compare the delivered word against a fixed constant.
  task automatic directed(input string nm, input logic [3:0] op, input logic [W-1:0] ia,
                          input logic [W-1:0] ib, input logic [W-1:0] er, input logic [W-1:0] eh,
                          input logic [4:0] ef, input int exp_lat, input int exp_low);
    int c0, low, lat;
    bit seen = 0;
    low = 0; lat = -1;
    rdy_mode = 0;
    issue(op, ia, ib, c0);
    for (int k = 0; k < 3 * W; k++) begin
      @(negedge clk);
      if (bus.out_valid) begin seen = 1; lat = cyc - c0; break; end
      if (!bus.in_ready) low++;
    end
    chk({nm, "_seen"}, 32'(seen), 32'd1);
    chk({nm, "_value"}, {11'd0, bus.res, bus.res_hi, bus.flags}, {11'd0, er, eh, ef});
    chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_in_ready_low"}, 32'(low), 32'(exp_low));
    @(posedge clk); #1;
  endtask

  task automatic drain(input string nm);
    rdy_mode = 0;
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) begin @(posedge clk); #1; end
    repeat (2) begin @(posedge clk); #1; end
    chk({nm, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int c_add, c_mul, dummy, gap;
    logic [3:0] op;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.opcode = '0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_outputs", {11'd0, bus.res, bus.res_hi, bus.flags}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;

    directed("add_ff_01", 4'd0, 8'hFF, 8'h01, 8'h00, 8'h00, 5'b00101, 1, 0);
    directed("add_7f_01", 4'd0, 8'h7F, 8'h01, 8'h80, 8'h00, 5'b01010, 1, 0);
    directed("sub_05_07", 4'd1, 8'h05, 8'h07, 8'hFE, 8'h00, 5'b00110, 1, 0);
    directed("asr_81",    4'd7, 8'h81, 8'h00, 8'hC0, 8'h00, 5'b00110, 1, 0);
    directed("lsr_81",    4'd8, 8'h81, 8'h00, 8'h40, 8'h00, 5'b00100, 1, 0);
    directed("lsl_81",    4'd9, 8'h81, 8'h00, 8'h02, 8'h00, 5'b00100, 1, 0);
    directed("op_1100",   4'd12, 8'h12, 8'h34, 8'hFF, 8'h00, 5'b10010, 1, 0);
    directed("mul_ff_ff", 4'd10, 8'hFF, 8'hFF, 8'h01, 8'hFE, 5'b00100, W + 1, W);
    directed("mul_00_37", 4'd10, 8'h00, 8'h37, 8'h00, 8'h00, 5'b00001, W + 1, W);

    // Four ANDs against a 1,0,0,1 ready pattern; the monitor enforces order and stability.
    rdy_mode = 2;
    for (int i = 0; i < 4; i++) issue(4'd2, 8'($urandom), 8'($urandom), dummy);
    drain("andstream");

    // MUL behind a stalled result: it must wait for the drain, then deliver.
    rdy_idx = 0; rdy_mode = 3;
    issue(4'd0, 8'h21, 8'h13, c_add);
    issue(4'd10, 8'hC3, 8'h5A, c_mul);
    chk("mul_waits_stall", 32'(c_mul - c_add >= 15), 32'd1);
    drain("hold");

    // Random traffic with random backpressure.
    rdy_mode = 1;
    for (int i = 0; i < 150; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 4'd10 : 4'($urandom_range(0, 15));
      issue(op, 8'($urandom), 8'($urandom), dummy);
      gap = $urandom_range(0, 2);
      repeat (gap) begin @(posedge clk); #1; end
    end
    drain("random");

    // Reset in the middle of a multiply aborts it.
    directed("pre_rst_add", 4'd0, 8'h03, 8'h04, 8'h07, 8'h00, 5'b00000, 1, 0);
    issue(4'd10, 8'h12, 8'h34, dummy);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_outputs", {11'd0, bus.res, bus.res_hi, bus.flags}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (W + 3) @(negedge clk);
    chk("aborted_no_result", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    directed("post_rst_add", 4'd0, 8'h10, 8'h20, 8'h30, 8'h00, 5'b00000, 1, 0);
    drain("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
